// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: pads a byte-packed word stream into 512-bit blocks, drives the
// compression core and chains H between blocks. Define SHA256_DOUBLE_EN for SHA-256d output.
module sha256_msg_feeder #(
    parameter int LEN_W       = 64,
    parameter int CAPTURE_DLY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    input  logic         s_last,
    input  logic [1:0]   s_nbytes,
    input  logic         s_empty,
    output logic         s_ready,
    output logic [255:0] core_h_in,
    output logic [511:0] core_m_in,
    output logic         core_start,
    input  logic         core_done,
    input  logic [255:0] core_h_out,
    output logic [255:0] dig_data,
    output logic         dig_valid,
    input  logic         dig_ready
);
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {IDLE, FILL, PAD, START, WAIT, CAPT, LEN, DONE} state_t;

    state_t           state;
    logic [31:0]      m [16];
    logic [4:0]       wcnt;
    logic [4:0]       pidx;      // word holding the 0x80 marker; 16 means it spills into the length block
    logic [LEN_W-1:0] bitcnt;
    logic [255:0]     h_reg;
    logic             final_blk;
    logic             len_pend;
    logic             len_mark;
    logic             done_seen;
    logic [1:0]       dcnt;
`ifdef SHA256_DOUBLE_EN
    logic             second;
`endif

    logic [63:0] len64;
    logic [5:0]  add_bits;
    logic [31:0] tail_word;

    assign len64     = 64'(bitcnt);
    assign core_h_in = h_reg;
    assign dig_data  = dig_valid ? h_reg : '0;

    always_comb begin
        add_bits = 6'd32;
        if (s_last) begin
            if (s_empty)
                add_bits = 6'd0;
            else if (s_nbytes != 2'd0)
                add_bits = {1'b0, s_nbytes, 3'b000};
        end
    end

    always_comb begin
        case (s_nbytes)
            2'd1:    tail_word = {s_data[31:24], 8'h80, 16'h0000};
            2'd2:    tail_word = {s_data[31:16], 8'h80, 8'h00};
            2'd3:    tail_word = {s_data[31:8], 8'h80};
            default: tail_word = 32'h8000_0000;
        endcase
    end

    always_comb begin
        core_m_in = '0;
        for (int i = 0; i < 16; i++)
            core_m_in[511 - 32*i -: 32] = m[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wcnt       <= '0;
            pidx       <= '0;
            bitcnt     <= '0;
            h_reg      <= IV;
            final_blk  <= 1'b0;
            len_pend   <= 1'b0;
            len_mark   <= 1'b0;
            done_seen  <= 1'b0;
            dcnt       <= '0;
            s_ready    <= 1'b0;
            core_start <= 1'b0;
            dig_valid  <= 1'b0;
`ifdef SHA256_DOUBLE_EN
            second     <= 1'b0;
`endif
            // NOTE: the block buffer is reset because it is a visible output (core_m_in).
            for (int i = 0; i < 16; i++)
                m[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in a branch override this default.
            core_start <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        state  <= FILL;
                        bitcnt <= bitcnt + LEN_W'(add_bits);
                        if (s_last) begin
                            s_ready <= 1'b0;
                            state   <= PAD;
                            if (s_empty) begin
                                m[wcnt[3:0]] <= 32'h8000_0000;
                                pidx         <= wcnt;
                            end else if (s_nbytes != 2'd0) begin
                                m[wcnt[3:0]] <= tail_word;
                                pidx         <= wcnt;
                            end else begin
                                m[wcnt[3:0]] <= s_data;
                                pidx         <= wcnt + 5'd1;
                                if (wcnt != 5'd15)
                                    m[wcnt[3:0] + 4'd1] <= 32'h8000_0000;
                            end
                        end else begin
                            m[wcnt[3:0]] <= s_data;
                            wcnt         <= wcnt + 5'd1;
                            if (wcnt == 5'd15) begin
                                s_ready    <= 1'b0;
                                final_blk  <= 1'b0;
                                state      <= START;
                                core_start <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    for (int i = 0; i < 16; i++)
                        if (5'(i) > pidx)
                            m[i] <= '0;
                    if (pidx <= 5'd13) begin
                        m[14]     <= len64[63:32];
                        m[15]     <= len64[31:0];
                        final_blk <= 1'b1;
                    end else begin
                        final_blk <= 1'b0;
                        len_pend  <= 1'b1;
                        len_mark  <= (pidx == 5'd16);
                    end
                    state      <= START;
                    core_start <= 1'b1;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (!done_seen) begin
                        if (core_done) begin
                            if (CAPTURE_DLY == 0)
                                state <= CAPT;
                            else
                                done_seen <= 1'b1;
                        end
                    end else if (dcnt == 2'(CAPTURE_DLY - 1)) begin
                        state <= CAPT;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                CAPT: begin
                    done_seen <= 1'b0;
                    dcnt      <= '0;
                    wcnt      <= '0;
                    h_reg     <= core_h_out;
                    if (!final_blk) begin
                        if (len_pend) begin
                            state <= LEN;
                        end else begin
                            state   <= FILL;
                            s_ready <= 1'b1;
                        end
                    end else begin
`ifdef SHA256_DOUBLE_EN
                        if (!second) begin
                            // Second pass hashes the 32-byte digest from a fresh IV.
                            second <= 1'b1;
                            h_reg  <= IV;
                            for (int i = 0; i < 8; i++)
                                m[i] <= core_h_out[255 - 32*i -: 32];
                            m[8] <= 32'h8000_0000;
                            for (int i = 9; i < 15; i++)
                                m[i] <= '0;
                            m[15]      <= 32'd256;
                            state      <= START;
                            core_start <= 1'b1;
                        end else begin
                            state     <= DONE;
                            dig_valid <= 1'b1;
                        end
`else
                        state     <= DONE;
                        dig_valid <= 1'b1;
`endif
                    end
                end
                LEN: begin
                    for (int i = 1; i < 14; i++)
                        m[i] <= '0;
                    m[0]       <= len_mark ? 32'h8000_0000 : 32'h0;
                    m[14]      <= len64[63:32];
                    m[15]      <= len64[31:0];
                    len_pend   <= 1'b0;
                    final_blk  <= 1'b1;
                    state      <= START;
                    core_start <= 1'b1;
                end
                DONE: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        h_reg     <= IV;
                        bitcnt    <= '0;
                        state     <= IDLE;
`ifdef SHA256_DOUBLE_EN
                        second    <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 core responder, digest scoreboard,
// directed messages covering padding boundaries, mid-block reset and consumer back-pressure.
module tb_sha256_msg_feeder;
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam int CORE_LAT = 16;
`ifdef SHA256_DOUBLE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         rst_n;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [1:0]   s_nbytes;
    logic         s_empty;
    logic         s_ready;
    logic [255:0] core_h_in;
    logic [511:0] core_m_in;
    logic         core_start;
    logic         core_done;
    logic [255:0] core_h_out;
    logic [255:0] dig_data;
    logic         dig_valid;
    logic         dig_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   msg_buf [128];
    logic [255:0] exp_q [$];
    logic [511:0] blk_q [$];
    int           n_starts = 0;
    logic         inject_done = 1'b0;

    sha256_msg_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_nbytes   (s_nbytes),
        .s_empty    (s_empty),
        .s_ready    (s_ready),
        .core_h_in  (core_h_in),
        .core_m_in  (core_m_in),
        .core_start (core_start),
        .core_done  (core_done),
        .core_h_out (core_h_out),
        .dig_data   (dig_data),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        return r;
    endfunction

    // 64 rounds without the final feed-forward addition.
    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++)
            w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a, b, c, d, e, f, g, hh};
    endfunction

    function automatic logic [255:0] sha256_ref(input int len);
        logic [7:0]   pb [192];
        logic [255:0] h;
        logic [511:0] blk;
        logic [63:0]  bits;
        int           nb;
        nb   = (len + 8) / 64 + 1;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < nb * 64; i++)
            pb[i] = (i < len) ? msg_buf[i] : ((i == len) ? 8'h80 : 8'h00);
        for (int k = 0; k < 8; k++)
            pb[nb*64 - 8 + k] = bits[63 - 8*k -: 8];
        h = IV;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 64; j++)
                blk[511 - 8*j -: 8] = pb[64*bi + j];
            h = add8(h, compress(h, blk));
        end
        return h;
    endfunction

    function automatic logic [255:0] fin(input logic [255:0] d);
`ifdef SHA256_DOUBLE_EN
        return add8(IV, compress(IV, {d, 32'h8000_0000, 160'h0, 64'd256}));
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] wrd(input logic [511:0] blk, input int i);
        return blk[511 - 32*i -: 32];
    endfunction

    // Compression core responder; re-reads H_in at completion like the real core.
    initial begin
        logic [255:0] lat_h;
        logic [511:0] lat_m;
        int           cnt;
        logic         busy;
        busy       = 1'b0;
        cnt        = 0;
        core_done  = 1'b0;
        core_h_out = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                continue;
            end
            if (inject_done) begin
                core_done   = 1'b1;
                core_h_out  = {8{$urandom}};
                inject_done = 1'b0;
            end
            if (core_start) begin
                check("start_while_busy", busy, 1'b0);
                busy  = 1'b1;
                cnt   = CORE_LAT;
                lat_h = core_h_in;
                lat_m = core_m_in;
                blk_q.push_back(core_m_in);
                n_starts++;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    check("h_in_stable", core_h_in, lat_h);
                    check("m_in_stable", core_m_in, lat_m);
                    check("s_ready_busy", s_ready, 1'b0);
                    core_h_out = add8(compress(lat_h, lat_m), core_h_in);
                    core_done  = 1'b1;
                    busy       = 1'b0;
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input logic last, input logic [1:0] nb, input logic emp);
        int t;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        t = 0;
        while (s_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            check("s_ready_timeout", s_ready, 1'b1);
            return;
        end
        s_data   = d;
        s_valid  = 1'b1;
        s_last   = last;
        s_nbytes = nb;
        s_empty  = emp;
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        s_last   = 1'($urandom);
        s_empty  = 1'b0;
        s_data   = $urandom;
    endtask

    // Bytes past the message end are filled with junk to prove they are masked.
    task automatic send_msg(input int len);
        logic [31:0] d;
        int          nw;
        if (len == 0) begin
            push_word($urandom, 1'b1, 2'($urandom), 1'b1);
            return;
        end
        nw = (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++)
                d[31 - 8*b -: 8] = (4*w + b < len) ? msg_buf[4*w + b] : 8'($urandom);
            push_word(d, w == nw - 1, (w == nw - 1) ? 2'(len % 4) : 2'($urandom), 1'b0);
        end
    endtask

    task automatic wait_digest(input string tag);
        int           t;
        logic [255:0] exp;
        t = 0;
        @(negedge clk);
        while (dig_valid !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, dig_valid, 1'b1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_digest"}, dig_data, exp);
        check({tag, "_s_ready_low"}, s_ready, 1'b0);
        dig_ready = 1'b1;
        @(posedge clk);
        #1;
        dig_ready = 1'b0;
        check({tag, "_released"}, dig_valid, 1'b0);
        check({tag, "_h_iv"}, core_h_in, IV);
    endtask

    task automatic set_abc();
        msg_buf[0] = 8'h61;
        msg_buf[1] = 8'h62;
        msg_buf[2] = 8'h63;
    endtask

    initial begin
        int n0;
        int b0;
        int t;
        logic seen;
        rst_n     = 1'b0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_nbytes  = '0;
        s_empty   = 1'b0;
        dig_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_dig_valid", dig_valid, 1'b0);
        check("rst_dig_data", dig_data, 256'h0);
        check("rst_core_m_in", core_m_in, 512'h0);
        check("rst_core_h_in", core_h_in, IV);
        rst_n = 1'b1;

        // "abc": single block
        set_abc();
        n0 = n_starts; b0 = blk_q.size();
        exp_q.push_back(fin(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        send_msg(3);
        wait_digest("abc");
        check("abc_starts", n_starts - n0, 1 + EXTRA);
        check("abc_block", blk_q[b0], {32'h6162_6380, 448'h0, 32'h18});

        // empty message
        n0 = n_starts; b0 = blk_q.size();
`ifdef SHA256_DOUBLE_EN
        exp_q.push_back(256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456);
`else
        exp_q.push_back(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
`endif
        send_msg(0);
        wait_digest("empty");
        check("empty_starts", n_starts - n0, 1 + EXTRA);
        check("empty_block", blk_q[b0], {32'h8000_0000, 480'h0});

        // 56-byte message: length spills into a second block
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 4; j++)
                msg_buf[4*i + j] = 8'(8'h61 + i + j);
        n0 = n_starts; b0 = blk_q.size();
        exp_q.push_back(fin(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));
        send_msg(56);
        wait_digest("m56");
        check("m56_starts", n_starts - n0, 2 + EXTRA);
        check("m56_w14", wrd(blk_q[b0], 14), 32'h8000_0000);
        check("m56_block2", blk_q[b0 + 1], {448'h0, 64'd448});

        // 55 x 'a': last byte count that still fits one block
        for (int i = 0; i < 64; i++)
            msg_buf[i] = 8'h61;
        n0 = n_starts; b0 = blk_q.size();
        exp_q.push_back(fin(sha256_ref(55)));
        send_msg(55);
        wait_digest("a55");
        check("a55_starts", n_starts - n0, 1 + EXTRA);
        check("a55_w13_lo", wrd(blk_q[b0], 13) & 32'hff, 32'h80);
        check("a55_w15", wrd(blk_q[b0], 15), 32'h0000_01b8);

        // 64 x 'a': full block, marker starts the length block
        n0 = n_starts; b0 = blk_q.size();
        exp_q.push_back(fin(sha256_ref(64)));
        send_msg(64);
        wait_digest("a64");
        check("a64_starts", n_starts - n0, 2 + EXTRA);
        check("a64_block1", blk_q[b0], {16{32'h6161_6161}});
        check("a64_block2", blk_q[b0 + 1], {32'h8000_0000, 416'h0, 64'h200});

        // stray core_done while idle is ignored
        n0 = n_starts;
        inject_done = 1'b1;
        repeat (8) @(negedge clk);
        check("stray_dig_valid", dig_valid, 1'b0);
        check("stray_s_ready", s_ready, 1'b1);
        check("stray_h", core_h_in, IV);
        check("stray_starts", n_starts - n0, 0);

        // reset 10 cycles into a block drops it
        set_abc();
        n0 = n_starts;
        send_msg(3);
        t = 0;
        while (n_starts == n0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_started", n_starts - n0, 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_start_low", core_start, 1'b0);
        check("rst_mid_valid", dig_valid, 1'b0);
        check("rst_mid_h", core_h_in, IV);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dig_valid !== 1'b0 || core_start !== 1'b0)
                seen = 1'b1;
        end
        check("rst_mid_quiet", seen, 1'b0);
        check("rst_mid_h_after", core_h_in, IV);
        exp_q.push_back(fin(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        send_msg(3);
        wait_digest("abc_again");

        // consumer back-pressure holds the digest
        set_abc();
        exp_q.push_back(fin(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        send_msg(3);
        t = 0;
        while (dig_valid !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_valid", dig_valid, 1'b1);
            check("hold_data", dig_data, exp_q[0]);
            check("hold_s_ready", s_ready, 1'b0);
        end
        wait_digest("hold");
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
